// File: rtl/fpio_fifo_drain_if.sv
// Handshake bundle between an fpio_fifo output side, the drain engine and the downstream sink.
// master = drain engine; slave = the FIFO/sink environment around it.
interface fpio_fifo_drain_if #(
    parameter int FIFO_BITS  = 4,
    parameter int DATA_WIDTH = 32
);
    logic [FIFO_BITS:0]    fifo_avail;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_data_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        input  fifo_avail, fifo_data, out_ready,
        output fifo_data_en, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_avail, fifo_data, out_ready,
        input  fifo_data_en, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fpio_fifo_drain.sv
// Pops words from an fpio_fifo (registered-SRAM read timing) into a 2-entry skid
// buffer and presents them as a valid/ready stream with burst framing and a drain count.
module fpio_fifo_drain #(
    parameter int FIFO_BITS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    fpio_fifo_drain_if.master   bus,
    output logic [31:0]         drained_count
);
    localparam int                BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    logic                  pop_q;
    logic [1:0]            occ;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [BEAT_W-1:0]     beat;
    logic                  push;
    logic                  take;

    // The pop_q gap keeps fifo_data and fifo_avail current whenever a pop is considered.
    assign push              = ~rst & en & (bus.fifo_avail != '0) & ~pop_q & (occ < 2'd2);
    assign bus.fifo_data_en  = push;
    assign bus.out_valid     = (occ != 2'd0);
    assign take              = bus.out_valid & bus.out_ready;
    assign bus.out_data      = buf_q[rd_ptr];
    assign bus.out_last      = bus.out_valid & (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_q         <= 1'b0;
            occ           <= 2'd0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
            beat          <= '0;
            drained_count <= 32'd0;
        end else begin
            pop_q <= push;

            if (push) begin
                buf_q[wr_ptr] <= bus.fifo_data;
                wr_ptr        <= ~wr_ptr;
            end

            if (take) begin
                rd_ptr        <= ~rd_ptr;
                drained_count <= drained_count + 32'd1;
                if (beat == LAST_BEAT)
                    beat <= '0;
                else
                    beat <= beat + BEAT_ONE;
            end

            case ({push, take})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpio_fifo_drain.sv
// Directed bench for fpio_fifo_drain: behavioural FIFO with registered read timing,
// scoreboard of loaded words checked at each output handshake, burst framing model.
module tb_fpio_fifo_drain;
    localparam int FB = 4;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int AW = FB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] drained_count;

    always #5 clk = ~clk;

    fpio_fifo_drain_if #(.FIFO_BITS(FB), .DATA_WIDTH(DW)) bus ();

    fpio_fifo_drain #(.FIFO_BITS(FB), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .bus           (bus),
        .drained_count (drained_count)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int            beat_m     = 0;
    logic [31:0]   drained_m  = 32'd0;
    int            pops       = 0;
    int            lasts_seen = 0;
    logic          pop_now    = 1'b0;
    logic          pop_prev   = 1'b0;
    logic          val_now    = 1'b0;
    logic          hold_prev  = 1'b0;
    logic [DW-1:0] data_prev  = '0;
    logic          last_prev  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bottom pointer moved last cycle -> read data not yet valid.
    task automatic drive_fifo();
        bus.fifo_avail = AW'(fq.size());
        if (pop_prev || fq.size() == 0)
            bus.fifo_data = 32'hDEAD_BEEF;
        else
            bus.fifo_data = fq[0];
    endtask

    task automatic load(input logic [DW-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        drive_fifo();
    endtask

    // Called just after a negedge with inputs set; returns after the next negedge.
    task automatic tick();
        logic hs;
        logic [DW-1:0] e;
        #1;
        pop_now = bus.fifo_data_en;
        val_now = bus.out_valid;
        hs      = bus.out_valid & bus.out_ready & ~rst;
        if (pop_now) begin
            chk("pop_spacing", 64'(pop_prev), 64'(0));
            chk("pop_underflow", 64'(fq.size() != 0), 64'(1));
        end
        if (!rst) chk("drained_count", 64'(drained_count), 64'(drained_m));
        if (hold_prev && !rst) begin
            chk("hold_data", 64'(bus.out_data), 64'(data_prev));
            chk("hold_last", 64'(bus.out_last), 64'(last_prev));
        end
        if (hs) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(e));
                chk("out_last", 64'(bus.out_last), 64'(beat_m == BL - 1));
            end
            if (bus.out_last) lasts_seen++;
            beat_m    = (beat_m + 1) % BL;
            drained_m = drained_m + 32'd1;
        end
        hold_prev = bus.out_valid & ~bus.out_ready & ~rst;
        data_prev = bus.out_data;
        last_prev = bus.out_last;
        @(posedge clk);
        @(negedge clk);
        if (pop_now && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
        end
        pop_prev = pop_now;
        if (rst) begin
            beat_m    = 0;
            drained_m = 32'd0;
            hold_prev = 1'b0;
        end
        drive_fifo();
    endtask

    task automatic run_until_empty(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_in_time", 64'(n < bound), 64'(1));
    endtask

    initial begin
        rst           = 1'b1;
        en            = 1'b1;
        bus.out_ready = 1'b1;
        bus.fifo_avail = '0;
        bus.fifo_data  = '0;
        @(negedge clk);

        // Reset held with words waiting
        for (int i = 0; i < 3; i++) load(32'h10 + 32'(i));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_pop", 64'(pop_now), 64'(0));
            chk("rst_valid", 64'(val_now), 64'(0));
            chk("rst_drained", 64'(drained_count), 64'(0));
        end
        chk("rst_out_valid_after", 64'(bus.out_valid), 64'(0));
        rst = 1'b0;
        tick();
        chk("first_pop_after_rst", 64'(pop_now), 64'(1));
        run_until_empty(40);

        // Streaming at peak rate
        for (int i = 0; i < 4; i++) load(32'hA0 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stream_pop", 64'(pop_now), 64'(i % 2 == 0));
            chk("stream_valid", 64'(val_now), 64'(i % 2 == 1));
        end
        chk("stream_sb_empty", 64'(exp_q.size()), 64'(0));
        chk("stream_drained", 64'(drained_count), 64'(7));

        // Empty FIFO
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("empty_pop", 64'(pop_now), 64'(0));
            chk("empty_valid", 64'(val_now), 64'(0));
        end

        // Backpressure
        bus.out_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 5; i++) load(32'hB0 + 32'(i));
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) chk("bp_head", 64'(bus.out_data), 64'(32'hB0));
        end
        chk("bp_pops", 64'(pops), 64'(2));
        chk("bp_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b1;
        run_until_empty(40);
        chk("bp_total_pops", 64'(pops), 64'(5));
        chk("bp_fifo_avail", 64'(bus.fifo_avail), 64'(0));

        // Burst framing under random backpressure
        lasts_seen = 0;
        for (int i = 0; i < 8; i++) load(32'hC0 + 32'(i));
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            chk("burst_in_time", 64'(n < 200), 64'(1));
        end
        chk("burst_lasts", 64'(lasts_seen), 64'(2));
        bus.out_ready = 1'b1;

        // Enable drop after the second pop
        pops = 0;
        for (int i = 0; i < 6; i++) load(32'hD0 + 32'(i));
        begin
            int n = 0;
            while (pops < 2 && n < 20) begin
                tick();
                n++;
            end
            chk("en_two_pops", 64'(pops), 64'(2));
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("en_low_pop", 64'(pop_now), 64'(0));
        end
        chk("en_low_drained", 64'(exp_q.size()), 64'(4));
        chk("en_low_valid", 64'(bus.out_valid), 64'(0));

        // Fill buffer, then reset mid-stream
        en = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("pre_rst_pops", 64'(pops), 64'(4));
        chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("post_rst_drained", 64'(drained_count), 64'(0));
        fq.delete();
        exp_q.delete();
        drive_fifo();
        bus.out_ready = 1'b1;
        lasts_seen = 0;
        for (int i = 0; i < 4; i++) load(32'hE0 + 32'(i));
        run_until_empty(40);
        chk("post_rst_burst_last", 64'(lasts_seen), 64'(1));

        // Full FIFO count wraps the low bits to zero but must still pop
        for (int i = 0; i < 16; i++) load(32'hF00 + 32'(i));
        chk("full_avail", 64'(bus.fifo_avail), 64'(16));
        tick();
        chk("full_pop", 64'(pop_now), 64'(1));
        run_until_empty(80);
        tick();
        chk("final_drained", 64'(drained_count), 64'(20));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
